demux3_buf: RTL and testbench
=============================

# demux3_buf

Registered 1-to-3 demultiplexer with valid/ready handshakes: the steering counterpart of the `mux3` select stage. One input word plus a 2-bit select is routed into one of three single-entry output buffers, and each buffer is drained independently by its own consumer. It sits between a shared producer, such as the multiplier result path, and three downstream consumers that may stall independently.

## Interface
- `WIDTH`, default 8: data word width in bits.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `d` input WIDTH: input data word.
- `s` input 2: destination select; decoded as `s[1]` ? channel 2 : (`s[0]` ? channel 1 : channel 0). `s=3` therefore selects channel 2.
- `in_valid` input 1: `d`/`s` are valid this cycle.
- `in_ready` output 1: block accepts `d` this cycle.
- `y0`, `y1`, `y2` output WIDTH: per-channel buffered data.
- `v0`, `v1`, `v2` output 1: per-channel buffer holds a valid word.
- `r0`, `r1`, `r2` input 1: per-channel consumer ready.

## Operation
- Each channel k has one register `yk` and one flag `vk`, and no other storage.
- Input transfer occurs when `in_valid & in_ready` at a rising edge.
- Output transfer on channel k occurs when `vk & rk` at a rising edge.
- `in_ready` is combinational:
  - `in_ready = !reset & (!vsel | rsel)`, where sel is the channel decoded from the current `s`.
  - It depends on `s` and on the selected `rk`, not on `in_valid`.
- Per channel k, at each edge:
  - If an input transfer targets k: `yk <= d` and `vk <= 1`. This holds whether or not an output transfer on k happens in the same cycle.
  - Else if an output transfer occurs on k: `vk <= 0` and `yk` holds its value.
  - Else: `yk` and `vk` hold.
- The channels are independent: one channel can fill while another drains, and a stalled channel does not block input aimed at a different channel.
- Stability: while `vk=1` and `rk=0`, `yk` and `vk` must not change.
- `d` and `s` are ignored when `in_valid=0`. No word is dropped or duplicated. Accepted words appear on their channel in acceptance order.

## Timing
- Reset, asynchronous and effective immediately:
  - `v0`–`v2` = 0 and `y0`–`y2` = 0.
  - `in_ready` = 0 while `reset` is high.
  - Any buffered words are discarded, including words in mid-handshake.
- First edge after `reset` falls: the block is fully empty, so `in_ready = 1` for any `s`.
- Latency: a word accepted at edge N is visible on `yk` with `vk=1` immediately after edge N, i.e. in cycle N+1.
- Throughput:
  - One word per cycle per channel when the consumer holds `rk=1`. Fill and drain in the same cycle keeps `vk=1` continuously.
  - Aggregate throughput is one input word per cycle.
- Full channel with `rk=0`: `in_ready=0` for that `s`, and the input must hold until the channel is ready.
- Full channel with `rk=1`: `in_ready=1`, giving pass-through replacement in the same cycle.
- Combinational paths: `s` → `in_ready`, and `rk` → `in_ready`. There is no path from `in_valid` to `in_ready`.

## Test plan
- Reset check: hold `reset=1` with `in_valid=1`, `d=8'hAA`. Required: `in_ready=0` and all `vk=0`. Release reset, drive `d=8'h11`, `s=0`. Required: `v0=1`, `y0=8'h11` after one edge.
- Routing: send `8'h10`, `8'h21`, `8'h32`, `8'h43` with `s=0,1,2,3` and all `rk=0`. Required:
  - After the first three edges, `y0=8'h10`, `y1=8'h21`, `y2=8'h32`.
  - The 4th word sees `in_ready=0`, because `s=3` maps to the full channel 2.
- Backpressure: fill channel 1 with `8'h5A` and keep `r1=0` for 5 cycles. Required:
  - `y1` stays `8'h5A` and `v1` stays 1.
  - `in_ready=0` for `s=1`.
  - `in_ready=1` for `s=0`, and a word `8'h77` sent on `s=0` lands on `y0`.
- Streaming: set `r2=1` and send `8'h01`..`8'h08` on `s=2` back-to-back. Required: `in_ready=1` every cycle, `v2=1` continuously, and `y2` shows `8'h01`..`8'h08` in order, one cycle after each acceptance.
- Simultaneous drain and fill: with `v0=1` and `y0=8'hC3`, drive `r0=1`, `d=8'h3C`, `s=0`. Required: both transfers complete at the same edge, then `y0=8'h3C` and `v0=1`.
- Mid-operation reset: with all three channels full, assert `reset` asynchronously between edges. Required: all `vk=0` and `yk=0` immediately, and the old words never reappear.

Source files
------------

// File: rtl/demux3_buf_if.sv
// Handshake bundle for demux3_buf: one shared producer port and three
// independent consumer ports, each a valid/ready pair.
interface demux3_buf_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] d;
   logic [1:0]       s;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic             v0;
   logic             v1;
   logic             v2;
   logic             r0;
   logic             r1;
   logic             r2;

   // Environment side: drives the producer word and the consumer readies.
   modport master (
      output d, s, in_valid, r0, r1, r2,
      input  in_ready, y0, y1, y2, v0, v1, v2
   );

   // Block side.
   modport slave (
      input  d, s, in_valid, r0, r1, r2,
      output in_ready, y0, y1, y2, v0, v1, v2
   );
endinterface

// File: rtl/demux3_buf.sv
// Registered 1-to-3 demux into single-entry buffers; a word is visible the cycle after acceptance.
// in_ready drops only when the selected buffer is full and its consumer stalls; other channels keep flowing.
module demux3_buf #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   demux3_buf_if.slave bus
);

   logic [WIDTH-1:0] r_y0;
   logic [WIDTH-1:0] r_y1;
   logic [WIDTH-1:0] r_y2;
   logic             r_v0;
   logic             r_v1;
   logic             r_v2;

   logic [2:0]       w_sel_oh;
   logic [2:0]       w_ch_rdy;
   logic             w_in_ready;
   logic [2:0]       w_fill;
   logic [2:0]       w_drain;

   // s=3 aliases channel 2 because s[1] is tested first.
   always_comb begin
      w_sel_oh = 3'b000;
      if (bus.s[1])
         w_sel_oh = 3'b100;
      else if (bus.s[0])
         w_sel_oh = 3'b010;
      else
         w_sel_oh = 3'b001;
   end

   assign w_ch_rdy   = {(!r_v2 | bus.r2), (!r_v1 | bus.r1), (!r_v0 | bus.r0)};
   assign w_in_ready = !reset & ((w_sel_oh & w_ch_rdy) != 3'b000);
   assign w_fill     = (bus.in_valid & w_in_ready) ? w_sel_oh : 3'b000;
   assign w_drain    = {(r_v2 & bus.r2), (r_v1 & bus.r1), (r_v0 & bus.r0)};

   // A fill takes priority over a drain so pass-through keeps v high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_y0 <= '0;
         r_y1 <= '0;
         r_y2 <= '0;
         r_v0 <= 1'b0;
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         if (w_fill[0]) begin
            r_y0 <= bus.d;
            r_v0 <= 1'b1;
         end else if (w_drain[0]) begin
            r_v0 <= 1'b0;
         end

         if (w_fill[1]) begin
            r_y1 <= bus.d;
            r_v1 <= 1'b1;
         end else if (w_drain[1]) begin
            r_v1 <= 1'b0;
         end

         if (w_fill[2]) begin
            r_y2 <= bus.d;
            r_v2 <= 1'b1;
         end else if (w_drain[2]) begin
            r_v2 <= 1'b0;
         end
      end
   end

   assign bus.in_ready = w_in_ready;
   assign bus.y0       = r_y0;
   assign bus.y1       = r_y1;
   assign bus.y2       = r_y2;
   assign bus.v0       = r_v0;
   assign bus.v1       = r_v1;
   assign bus.v2       = r_v2;

endmodule

// File: tb/tb_demux3_buf.sv
// Directed bench for demux3_buf: reset, routing, backpressure, streaming,
// simultaneous drain/fill and asynchronous mid-operation reset.
module tb_demux3_buf;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fails;

   demux3_buf_if #(.WIDTH(8)) bus ();

   demux3_buf #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [1:0] sel, input logic [7:0] dat);
      bus.in_valid = vld;
      bus.s        = sel;
      bus.d        = dat;
      #1;
   endtask

   logic [7:0] route_words [0:2];

   initial begin
      n_checks = 0;
      n_fails  = 0;
      route_words[0] = 8'h10;
      route_words[1] = 8'h21;
      route_words[2] = 8'h32;

      reset = 1'b1;
      bus.r0 = 1'b0;
      bus.r1 = 1'b0;
      bus.r2 = 1'b0;
      drive(1'b1, 2'd0, 8'hAA);

      // Reset held with a valid word offered
      repeat (2) edge_step();
      chk("rst_in_ready", 8'(bus.in_ready), 8'd0);
      chk("rst_v0", 8'(bus.v0), 8'd0);
      chk("rst_v1", 8'(bus.v1), 8'd0);
      chk("rst_v2", 8'(bus.v2), 8'd0);
      chk("rst_y0", bus.y0, 8'h00);

      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'(i), 8'h11);
         chk($sformatf("empty_in_ready_s%0d", i), 8'(bus.in_ready), 8'd1);
      end
      drive(1'b1, 2'd0, 8'h11);
      edge_step();
      chk("first_v0", 8'(bus.v0), 8'd1);
      chk("first_y0", bus.y0, 8'h11);
      drive(1'b0, 2'd0, 8'h00);

      bus.r0 = 1'b1;
      edge_step();
      chk("drain_v0", 8'(bus.v0), 8'd0);
      bus.r0 = 1'b0;

      // Routing with all consumers stalled
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'(i), route_words[i]);
         chk($sformatf("route_in_ready_%0d", i), 8'(bus.in_ready), 8'd1);
         edge_step();
      end
      chk("route_y0", bus.y0, 8'h10);
      chk("route_y1", bus.y1, 8'h21);
      chk("route_y2", bus.y2, 8'h32);
      chk("route_v0", 8'(bus.v0), 8'd1);
      chk("route_v1", 8'(bus.v1), 8'd1);
      chk("route_v2", 8'(bus.v2), 8'd1);
      drive(1'b1, 2'd3, 8'h43);
      chk("route_s3_in_ready", 8'(bus.in_ready), 8'd0);
      edge_step();
      chk("route_s3_y2_hold", bus.y2, 8'h32);
      drive(1'b0, 2'd0, 8'h00);

      bus.r0 = 1'b1;
      bus.r1 = 1'b1;
      bus.r2 = 1'b1;
      edge_step();
      chk("drain_all_v", 8'({bus.v2, bus.v1, bus.v0}), 8'd0);
      bus.r0 = 1'b0;
      bus.r1 = 1'b0;
      bus.r2 = 1'b0;

      // Backpressure on channel 1
      drive(1'b1, 2'd1, 8'h5A);
      edge_step();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 2'd1, 8'h99);
         chk($sformatf("bp_in_ready_s1_%0d", i), 8'(bus.in_ready), 8'd0);
         edge_step();
         chk($sformatf("bp_y1_%0d", i), bus.y1, 8'h5A);
         chk($sformatf("bp_v1_%0d", i), 8'(bus.v1), 8'd1);
      end
      drive(1'b1, 2'd0, 8'h77);
      chk("bp_in_ready_s0", 8'(bus.in_ready), 8'd1);
      edge_step();
      chk("bp_y0", bus.y0, 8'h77);
      chk("bp_v0", 8'(bus.v0), 8'd1);
      chk("bp_y1_after", bus.y1, 8'h5A);
      drive(1'b0, 2'd0, 8'h00);

      // Streaming on channel 2
      bus.r2 = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 2'd2, 8'(i));
         chk($sformatf("stream_in_ready_%0d", i), 8'(bus.in_ready), 8'd1);
         edge_step();
         chk($sformatf("stream_y2_%0d", i), bus.y2, 8'(i));
         chk($sformatf("stream_v2_%0d", i), 8'(bus.v2), 8'd1);
      end
      drive(1'b0, 2'd0, 8'h00);
      edge_step();
      chk("stream_v2_end", 8'(bus.v2), 8'd0);
      bus.r2 = 1'b0;

      // Replace 77 with C3 via pass-through, then hold it
      bus.r0 = 1'b1;
      drive(1'b1, 2'd0, 8'hC3);
      chk("pass_in_ready", 8'(bus.in_ready), 8'd1);
      edge_step();
      bus.r0 = 1'b0;
      drive(1'b0, 2'd0, 8'h00);
      edge_step();
      chk("hold_y0", bus.y0, 8'hC3);
      chk("hold_v0", 8'(bus.v0), 8'd1);
      bus.r0 = 1'b1;
      drive(1'b1, 2'd0, 8'h3C);
      chk("sim_in_ready", 8'(bus.in_ready), 8'd1);
      edge_step();
      chk("sim_y0", bus.y0, 8'h3C);
      chk("sim_v0", 8'(bus.v0), 8'd1);
      bus.r0 = 1'b0;
      drive(1'b0, 2'd0, 8'h00);

      // Fill channel 2, then reset asynchronously between edges
      drive(1'b1, 2'd2, 8'hE2);
      edge_step();
      drive(1'b0, 2'd0, 8'h00);
      chk("full_v", 8'({bus.v2, bus.v1, bus.v0}), 8'h07);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_v", 8'({bus.v2, bus.v1, bus.v0}), 8'd0);
      chk("arst_y0", bus.y0, 8'h00);
      chk("arst_y1", bus.y1, 8'h00);
      chk("arst_y2", bus.y2, 8'h00);
      chk("arst_in_ready", 8'(bus.in_ready), 8'd0);
      edge_step();
      reset = 1'b0;
      edge_step();
      chk("post_rst_v", 8'({bus.v2, bus.v1, bus.v0}), 8'd0);
      chk("post_rst_y1", bus.y1, 8'h00);
      chk("post_rst_in_ready", 8'(bus.in_ready), 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
